tap_delay_line: RTL and testbench

Parametrised, registered tap delay line for the 1D-convolution datapath. It generalises the plain 32-bit clocked register into a chain of DEPTH registers, each WIDTH bits wide, that advances only on accepted samples. All taps are exposed in parallel to the MAC stage. The block tracks how full the window is and emits a one-cycle window-valid strobe at a configurable stride, so downstream multiply-accumulate runs only on complete, correctly strided windows.

---
 rtl/tap_delay_line_if.sv | 25 ++
 rtl/tap_delay_line.sv | 69 ++++++
 tb/tb_tap_delay_line.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tap_delay_line_if.sv
// rtl/tap_delay_line_if.sv - sample stream in, parallel taps and window strobe out
interface tap_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int FW = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [DEPTH-1:0]       tap_valid;
  logic [FW-1:0]          fill_count;
  logic                   window_valid;

  modport master (
    output flush, in_valid, in_data,
    input  taps, tap_valid, fill_count, window_valid
  );

  modport slave (
    input  flush, in_valid, in_data,
    output taps, tap_valid, fill_count, window_valid
  );
endinterface

// File: rtl/tap_delay_line.sv
// rtl/tap_delay_line.sv - accept-driven tap delay line with fill tracking and strided window strobe
module tap_delay_line #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 1
) (
  input logic                clk,
  input logic                reset,
  tap_delay_line_if.slave    bus
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] taps_q, taps_d;
  logic [DEPTH-1:0]            tap_valid_q, tap_valid_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [PW-1:0]               phase_q, phase_d;
  logic                        wv_q, wv_d;

  always_comb begin
    taps_d      = taps_q;
    tap_valid_d = tap_valid_q;
    fill_d      = fill_q;
    phase_d     = phase_q;
    wv_d        = 1'b0;

    // Flush clears first so a same-cycle sample lands in an empty line.
    if (bus.flush) begin
      taps_d      = '0;
      tap_valid_d = '0;
      fill_d      = '0;
      phase_d     = '0;
    end

    if (bus.in_valid) begin
      taps_d      = {taps_d[DEPTH-2:0], bus.in_data};
      tap_valid_d = {tap_valid_d[DEPTH-2:0], 1'b1};
      if (fill_d != FW'(DEPTH)) begin
        fill_d = fill_d + FW'(1);
      end
      // Phase only runs once the window is complete; first full window always emits.
      if (fill_d == FW'(DEPTH)) begin
        wv_d    = (phase_d == '0);
        phase_d = (phase_d == PW'(STRIDE - 1)) ? '0 : phase_d + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taps_q      <= '0;
      tap_valid_q <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      wv_q        <= 1'b0;
    end else begin
      taps_q      <= taps_d;
      tap_valid_q <= tap_valid_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      wv_q        <= wv_d;
    end
  end

  assign bus.taps         = taps_q;
  assign bus.tap_valid    = tap_valid_q;
  assign bus.fill_count   = fill_q;
  assign bus.window_valid = wv_q;
endmodule

// File: tb/tb_tap_delay_line.sv
// tb/tb_tap_delay_line.sv - directed scoreboard bench for tap_delay_line (STRIDE 1 and 2 instances)
module tb_tap_delay_line;
  logic clk = 1'b0;
  logic rst_a, rst_b;

  always #5 clk = ~clk;

  tap_delay_line_if #(.WIDTH(32), .DEPTH(4)) if_a ();
  tap_delay_line_if #(.WIDTH(32), .DEPTH(4)) if_b ();

  tap_delay_line #(.WIDTH(32), .DEPTH(4), .STRIDE(1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a.slave)
  );

  tap_delay_line #(.WIDTH(32), .DEPTH(4), .STRIDE(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b.slave)
  );

  typedef struct {
    int           dut;
    logic [127:0] taps;
    logic [3:0]   tv;
    logic [2:0]   fc;
    logic         wv;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic idle_all();
    rst_a = 1'b0; if_a.flush = 1'b0; if_a.in_valid = 1'b0; if_a.in_data = '0;
    rst_b = 1'b0; if_b.flush = 1'b0; if_b.in_valid = 1'b0; if_b.in_data = '0;
  endtask

  task automatic step(input int dut, input bit rs, input bit fl, input bit v,
                      input logic [31:0] d,
                      input logic [31:0] e3, input logic [31:0] e2,
                      input logic [31:0] e1, input logic [31:0] e0,
                      input logic [3:0] etv, input logic [2:0] efc, input bit ewv,
                      input string tag);
    exp_t e;
    exp_t got;
    logic [127:0] o_taps;
    logic [3:0]   o_tv;
    logic [2:0]   o_fc;
    logic         o_wv;
    idle_all();
    if (dut == 0) begin
      rst_a = rs; if_a.flush = fl; if_a.in_valid = v; if_a.in_data = d;
    end else begin
      rst_b = rs; if_b.flush = fl; if_b.in_valid = v; if_b.in_data = d;
    end
    e.dut = dut; e.taps = {e3, e2, e1, e0}; e.tv = etv; e.fc = efc; e.wv = ewv; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.dut == 0) begin
      o_taps = if_a.taps; o_tv = if_a.tap_valid; o_fc = if_a.fill_count; o_wv = if_a.window_valid;
    end else begin
      o_taps = if_b.taps; o_tv = if_b.tap_valid; o_fc = if_b.fill_count; o_wv = if_b.window_valid;
    end
    vectors++;
    assert (o_taps === got.taps) else begin
      miscompares++;
      $error("FAIL %s taps: observed %h expected %h", got.tag, o_taps, got.taps);
    end
    vectors++;
    assert (o_tv === got.tv) else begin
      miscompares++;
      $error("FAIL %s tap_valid: observed %b expected %b", got.tag, o_tv, got.tv);
    end
    vectors++;
    assert (o_fc === got.fc) else begin
      miscompares++;
      $error("FAIL %s fill_count: observed %0d expected %0d", got.tag, o_fc, got.fc);
    end
    vectors++;
    assert (o_wv === got.wv) else begin
      miscompares++;
      $error("FAIL %s window_valid: observed %b expected %b", got.tag, o_wv, got.wv);
    end
  endtask

  initial begin
    idle_all();

    // STRIDE=1 instance: reset with a live sample present
    step(0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_a0");
    step(0, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_a1");

    // fill 1..6
    step(0, 0, 0, 1, 1, 0, 0, 0, 1, 4'b0001, 1, 0, "fill1");
    step(0, 0, 0, 1, 2, 0, 0, 1, 2, 4'b0011, 2, 0, "fill2");
    step(0, 0, 0, 1, 3, 0, 1, 2, 3, 4'b0111, 3, 0, "fill3");
    step(0, 0, 0, 1, 4, 1, 2, 3, 4, 4'b1111, 4, 1, "fill4");
    step(0, 0, 0, 1, 5, 2, 3, 4, 5, 4'b1111, 4, 1, "fill5");
    step(0, 0, 0, 1, 6, 3, 4, 5, 6, 4'b1111, 4, 1, "fill6");
    step(0, 0, 0, 0, 99, 3, 4, 5, 6, 4'b1111, 4, 0, "idle_full");

    // flush alone, then bubbles
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, "flush");
    step(0, 0, 0, 1, 10, 0, 0, 0, 10, 4'b0001, 1, 0, "bub10");
    step(0, 0, 0, 1, 11, 0, 0, 10, 11, 4'b0011, 2, 0, "bub11");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h55, 0, 0, 10, 11, 4'b0011, 2, 0, "bub_idle");
    end
    step(0, 0, 0, 1, 12, 0, 10, 11, 12, 4'b0111, 3, 0, "bub12");
    step(0, 0, 0, 1, 13, 10, 11, 12, 13, 4'b1111, 4, 1, "bub13");

    // flush with sample
    step(0, 0, 1, 1, 1, 0, 0, 0, 1, 4'b0001, 1, 0, "refill1");
    step(0, 0, 0, 1, 2, 0, 0, 1, 2, 4'b0011, 2, 0, "refill2");
    step(0, 0, 0, 1, 3, 0, 1, 2, 3, 4'b0111, 3, 0, "refill3");
    step(0, 0, 0, 1, 4, 1, 2, 3, 4, 4'b1111, 4, 1, "refill4");
    step(0, 0, 1, 1, 7, 0, 0, 0, 7, 4'b0001, 1, 0, "flush7");
    step(0, 0, 0, 1, 8, 0, 0, 7, 8, 4'b0011, 2, 0, "fl8");
    step(0, 0, 0, 1, 9, 0, 7, 8, 9, 4'b0111, 3, 0, "fl9");
    step(0, 0, 0, 1, 10, 7, 8, 9, 10, 4'b1111, 4, 1, "fl10");

    // STRIDE=2 instance
    step(1, 1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_b");
    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 4'b0001, 1, 0, "s2_1");
    step(1, 0, 0, 1, 2, 0, 0, 1, 2, 4'b0011, 2, 0, "s2_2");
    step(1, 0, 0, 1, 3, 0, 1, 2, 3, 4'b0111, 3, 0, "s2_3");
    step(1, 0, 0, 1, 4, 1, 2, 3, 4, 4'b1111, 4, 1, "s2_4");
    step(1, 0, 0, 1, 5, 2, 3, 4, 5, 4'b1111, 4, 0, "s2_5");
    step(1, 0, 0, 1, 6, 3, 4, 5, 6, 4'b1111, 4, 1, "s2_6");
    step(1, 0, 0, 0, 0, 3, 4, 5, 6, 4'b1111, 4, 0, "s2_idle");
    step(1, 0, 0, 1, 7, 4, 5, 6, 7, 4'b1111, 4, 0, "s2_7");
    step(1, 0, 0, 1, 8, 5, 6, 7, 8, 4'b1111, 4, 1, "s2_8");
    step(1, 0, 0, 1, 9, 6, 7, 8, 9, 4'b1111, 4, 0, "s2_9");
    step(1, 0, 0, 1, 10, 7, 8, 9, 10, 4'b1111, 4, 1, "s2_10");

    // reset with phase=1: next full window must emit immediately
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_mid");
    step(1, 0, 0, 1, 21, 0, 0, 0, 21, 4'b0001, 1, 0, "s2r_1");
    step(1, 0, 0, 1, 22, 0, 0, 21, 22, 4'b0011, 2, 0, "s2r_2");
    step(1, 0, 0, 1, 23, 0, 21, 22, 23, 4'b0111, 3, 0, "s2r_3");
    step(1, 0, 0, 1, 24, 21, 22, 23, 24, 4'b1111, 4, 1, "s2r_4");
    step(1, 0, 0, 1, 25, 22, 23, 24, 25, 4'b1111, 4, 0, "s2r_5");

    idle_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
